writeback_queue: RTL and testbench
==================================

Name: writeback_queue

Overview:
- Write-side initiator for the pipeline's 2R1W register file.
- Accepts retiring results from two sources: the execute/ALU path and the memory/load path.
- Buffers results in a small in-order FIFO and drains exactly one write per cycle onto the register file's single write port (WE3/A3/WD3).
- Exposes two pending-write lookup ports so the decode stage can forward queued values not yet committed to the register file.

Parameters:
- DATA_WIDTH, 32, width of result data and WD3.
- ADDR_WIDTH, 5, width of register addresses.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  ALU result offered.
- ex_rd  in  ADDR_WIDTH  ALU destination register.
- ex_data  in  DATA_WIDTH  ALU result.
- ex_ready  out  1  ALU result accepted this cycle when ex_valid && ex_ready.
- mem_valid  in  1  load result offered.
- mem_rd  in  ADDR_WIDTH  load destination register.
- mem_data  in  DATA_WIDTH  load result.
- mem_ready  out  1  load accepted when mem_valid && mem_ready.
- WE3  out  1  register file write enable.
- A3  out  ADDR_WIDTH  register file write address.
- WD3  out  DATA_WIDTH  register file write data.
- A1  in  ADDR_WIDTH  lookup address 1 (decode rs1).
- A2  in  ADDR_WIDTH  lookup address 2 (decode rs2).
- fwd1_hit  out  1  a queued write targets A1.
- fwd1_data  out  DATA_WIDTH  data of the youngest queued write to A1.
- fwd2_hit  out  1  a queued write targets A2.
- fwd2_data  out  DATA_WIDTH  data of the youngest queued write to A2.

Behaviour:
- State: storage of DEPTH x {rd, data}, plus head pointer, tail pointer and count (0..DEPTH).
- Reset (rst_n low, asynchronous): count=0, pointers=0, storage contents don't-care.
  - While in reset and after it: WE3=0, A3=0, WD3=0, fwd*_hit=0, fwd*_data=0.
  - Reset mid-operation discards all queued writes; none reach the register file.
- Drain: WE3 = (count != 0); A3/WD3 = head entry, driven combinationally.
  - Head is popped at every rising edge where count != 0.
  - The register file commits at that same edge.
  - When count == 0: A3=0, WD3=0.
- Latency: a result accepted at edge N into an empty queue appears on WE3 during cycle N..N+1 and is committed at edge N+1.
- Ready (combinational from registered count and mem_valid; never depends on the same-cycle pop). With free = DEPTH - count:
  - mem_ready = (free >= 1).
  - ex_ready = (free >= 2) || (free >= 1 && !mem_valid).
- Simultaneous acceptance: mem entry is enqueued first (older), ex entry second. Both pushes and one pop may occur in the same edge.
  - Count update: count + pushes - pop.
- rd == 0: the handshake completes normally, but nothing is enqueued.
  - The entry never occupies a slot and never drives WE3.
- Ordering: strictly FIFO; queued writes to the same rd commit oldest first, so the register file ends with the youngest value.
- Lookup (combinational):
  - fwdX_hit = 1 iff some valid entry has rd == AX and AX != 0.
  - fwdX_data = data of the youngest such entry; 0 when no hit.
  - The head entry being written this cycle still counts as a hit.
  - Results being offered on ex_/mem_ this cycle are not visible.
- Pointer wrap: head and tail wrap modulo DEPTH; full when count == DEPTH, empty when count == 0.

Optional Feature:
- Macro: WB_QUEUE_STATS_EN.
- Defined: adds outputs stall_cycles (16-bit) and writes_committed (16-bit).
  - Both reset to 0 and saturate at 16'hFFFF.
  - stall_cycles increments on every edge where (ex_valid && !ex_ready) || (mem_valid && !mem_ready).
  - writes_committed increments on every edge where WE3 == 1.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then single ALU result: ex rd=5, data=32'hDEAD_BEEF for 1 cycle -> next cycle WE3=1, A3=5, WD3=32'hDEADBEEF for exactly 1 cycle; fwd1_hit=1 with A1=5 during that cycle.
- Same cycle mem rd=3/32'h11 and ex rd=3/32'h22, queue empty -> two consecutive writes, 32'h11 then 32'h22; fwd1_data=32'h22 while both are queued, 32'h22 while only the second remains.
- Fill to DEPTH=4 with WE3 drained but offers every cycle -> mem_ready stays 1 and ex_ready drops exactly when free < 2 with mem_valid=1; no write lost or duplicated; output order matches acceptance order.
- ex rd=0, data=32'hFFFF_FFFF -> ex_ready=1, no WE3 pulse, count unchanged; A1=0 gives fwd1_hit=0.
- 3 entries queued, rst_n pulsed low mid-cycle -> WE3 drops immediately (asynchronously); after release, no writes emitted and ex_ready=mem_ready=1.
- WB_QUEUE_STATS_EN defined: 10 accepted writes, 3 refused-offer cycles -> writes_committed=10, stall_cycles=3.

Source files
------------

// File: rtl/writeback_queue.sv
// In-order write-back FIFO feeding the register file's single write port (WE3/A3/WD3),
// with two pending-write lookup ports for decode forwarding. Define WB_QUEUE_STATS_EN for stall/commit counters.
module writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_data,
  output logic                  ex_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic                  WE3,
  output logic [ADDR_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0] WD3,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  output logic                  fwd1_hit,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic                  fwd2_hit,
  output logic [DATA_WIDTH-1:0] fwd2_data
`ifdef WB_QUEUE_STATS_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           writes_committed
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

  logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next, tail_reg, tail_next, ex_slot;
  logic [PTR_W:0]   count_reg, count_next, free;
  logic             mem_push, ex_push, pop;
  logic [DEPTH-1:0] slot_valid;

  // Ready looks only at registered occupancy so it never waits on this cycle's pop.
  assign free      = DEPTH_C - count_reg;
  assign mem_ready = (free != '0);
  assign ex_ready  = (free >= TWO_C) || ((free != '0) && !mem_valid);

  // Writes to x0 complete the handshake but are dropped here.
  assign mem_push = mem_valid && mem_ready && (mem_rd != '0);
  assign ex_push  = ex_valid && ex_ready && (ex_rd != '0);
  assign pop      = (count_reg != '0);
  assign ex_slot  = tail_reg + PTR_W'(mem_push);

  always_comb begin
    head_next  = head_reg + PTR_W'(pop);
    tail_next  = tail_reg + PTR_W'(mem_push) + PTR_W'(ex_push);
    count_next = count_reg + (PTR_W+1)'(mem_push) + (PTR_W+1)'(ex_push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage needs no reset: slot_valid gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_push && tail_reg == PTR_W'(i)) begin
        rd_mem[i]   <= mem_rd;
        data_mem[i] <= mem_data;
      end else if (ex_push && ex_slot == PTR_W'(i)) begin
        rd_mem[i]   <= ex_rd;
        data_mem[i] <= ex_data;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] age;
    assign age            = PTR_W'(gi) - head_reg;
    assign slot_valid[gi] = ({1'b0, age} < count_reg);
  end

  assign WE3 = pop;
  assign A3  = pop ? rd_mem[head_reg]   : '0;
  assign WD3 = pop ? data_mem[head_reg] : '0;

  // Walk oldest to youngest so the last match is the youngest write.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_reg + PTR_W'(k);
      if (slot_valid[idx] && (A1 != '0) && (rd_mem[idx] == A1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = data_mem[idx];
      end
      if (slot_valid[idx] && (A2 != '0) && (rd_mem[idx] == A2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = data_mem[idx];
      end
    end
  end

`ifdef WB_QUEUE_STATS_EN
  logic stall;
  assign stall = (ex_valid && !ex_ready) || (mem_valid && !mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles     <= '0;
      writes_committed <= '0;
    end else begin
      if (stall && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (WE3 && writes_committed != 16'hFFFF)
        writes_committed <= writes_committed + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: accepted writes are queued in the bench and
// compared against WE3/A3/WD3 and the forwarding ports on every falling edge.
module tb_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, mem_valid;
  logic [4:0]  ex_rd, mem_rd, A1, A2, A3;
  logic [31:0] ex_data, mem_data, WD3, fwd1_data, fwd2_data;
  logic        ex_ready, mem_ready, WE3, fwd1_hit, fwd2_hit;
`ifdef WB_QUEUE_STATS_EN
  logic [15:0] stall_cycles, writes_committed;
`endif

  writeback_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .A1(A1), .A2(A2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
`ifdef WB_QUEUE_STATS_EN
    , .stall_cycles(stall_cycles), .writes_committed(writes_committed)
`endif
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   exp_wc  = 0;
  int   exp_sc  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] fwd_model(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    if (a != 0)
      foreach (sb[i])
        if (sb[i].rd == a) r = {1'b1, sb[i].data};
    return r;
  endfunction

  // One clock: drive offers, check outputs at the falling edge, update the scoreboard at the rising edge.
  task automatic step(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    int          free;
    logic        exp_mr, exp_er;
    logic [32:0] f1, f2;
    ex_valid = ev;  ex_rd = erd;  ex_data = ed;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    @(negedge clk);
    free   = 4 - sb.size();
    exp_mr = (free >= 1);
    exp_er = (free >= 2) || (free >= 1 && !mv);
    check("mem_ready", mem_ready, exp_mr);
    check("ex_ready", ex_ready, exp_er);
    if (sb.size() != 0) begin
      check("WE3", WE3, 1);
      check("A3", A3, sb[0].rd);
      check("WD3", WD3, sb[0].data);
      exp_wc++;
    end else begin
      check("WE3", WE3, 0);
      check("A3", A3, 0);
      check("WD3", WD3, 0);
    end
    if ((ev && !exp_er) || (mv && !exp_mr)) exp_sc++;
    f1 = fwd_model(A1);
    f2 = fwd_model(A2);
    check("fwd1_hit", fwd1_hit, f1[32]);
    check("fwd1_data", fwd1_data, f1[31:0]);
    check("fwd2_hit", fwd2_hit, f2[32]);
    check("fwd2_data", fwd2_data, f2[31:0]);
    $display("t=%0t ex(%b,%0d,%h) mem(%b,%0d,%h) rdy=%b%b WE3=%b A3=%0d WD3=%h q=%0d",
             $time, ev, erd, ed, mv, mrd, md, ex_ready, mem_ready, WE3, A3, WD3, sb.size());
    @(posedge clk);
    if (sb.size() != 0) void'(sb.pop_front());
    if (mv && exp_mr && mrd != 0) sb.push_back('{rd: mrd, data: md});
    if (ev && exp_er && erd != 0) sb.push_back('{rd: erd, data: ed});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; ex_valid = 0; mem_valid = 0;
    ex_rd = 0; mem_rd = 0; ex_data = 0; mem_data = 0; A1 = 5; A2 = 3;
    #12;
    check("rst WE3", WE3, 0);
    check("rst A3", A3, 0);
    check("rst WD3", WD3, 0);
    check("rst fwd1_hit", fwd1_hit, 0);
    check("rst fwd2_data", fwd2_data, 0);
    check("rst ex_ready", ex_ready, 1);
    check("rst mem_ready", mem_ready, 1);
    rst_n = 1;
    @(posedge clk); #1;

    // Single ALU result, visible for exactly one cycle
    A1 = 5; A2 = 0;
    step(1, 5, 32'hDEAD_BEEF, 0, 0, 0);
    idle(2);

    // Same-cycle mem then ex to the same rd
    A1 = 3; A2 = 3;
    step(1, 3, 32'h22, 1, 3, 32'h11);
    idle(3);

    // Sustained dual offers fill the queue; ex is throttled
    A1 = 9; A2 = 2;
    for (int i = 0; i < 8; i++)
      step(1, 5'(i + 1), 32'hA000_0000 + i, 1, 5'(i + 9), 32'hB000_0000 + i);
    idle(5);

    // Write to x0 is swallowed
    A1 = 0; A2 = 0;
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    idle(2);

    // Reset with three entries queued
    A1 = 3; A2 = 4;
    step(1, 2, 32'h200, 1, 1, 32'h100);
    step(1, 4, 32'h400, 1, 3, 32'h300);
    ex_valid = 0; mem_valid = 0;
    #2;
    check("pre-rst WE3", WE3, sb.size() != 0);
    rst_n = 0;
    #1;
    check("async WE3", WE3, 0);
    check("async A3", A3, 0);
    check("async WD3", WD3, 0);
    check("async fwd1_hit", fwd1_hit, 0);
    check("async fwd2_data", fwd2_data, 0);
    sb.delete();
    exp_wc = 0;
    exp_sc = 0;
    #4;
    rst_n = 1;
    @(posedge clk); #1;
    idle(3);

    // Random traffic with collisions on rd and lookups
    for (int i = 0; i < 150; i++) begin
      A1 = 5'($urandom_range(0, 7));
      A2 = 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(6);

`ifdef WB_QUEUE_STATS_EN
    @(negedge clk);
    check("writes_committed", writes_committed, exp_wc);
    check("stall_cycles", stall_cycles, exp_sc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
